// File: rtl/sub_new_core_pkg.sv
// Shared constants for the subtractor core: default width and flag bit positions.
package sub_new_core_pkg;

   localparam int unsigned WIDTH_DEFAULT = 32;

   localparam int unsigned NUM_FLAGS   = 4;
   localparam int unsigned FLAG_BORROW = 0;
   localparam int unsigned FLAG_OVF    = 1;
   localparam int unsigned FLAG_ZERO   = 2;
   localparam int unsigned FLAG_NEG    = 3;

   typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/sub_new_core_cla4.sv
// 4-bit carry-lookahead slice: sum bits plus group propagate/generate for the
// next lookahead level.
module sub_new_core_cla4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] s_o,
   output logic       p_o,
   output logic       g_o
);

   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   // Every internal carry is a flat function of cin, so no ripple within the slice.
   assign c[0] = cin_i;
   assign c[1] = g[0] | (p[0] & cin_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

   assign s_o = p ^ c;
   assign p_o = &p;
   assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/sub_new_core.sv
// Combinational subtractor z = x - y built from 4-bit CLA slices, with
// borrow/overflow/zero/negative flags registered on each rising clock edge.
module sub_new_core
   import sub_new_core_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z,
   output logic             borrow,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int unsigned NumGroups = WIDTH / 4;

   logic [WIDTH-1:0]     y_inv;
   logic [NumGroups-1:0] grp_p;
   logic [NumGroups-1:0] grp_g;
   logic [NumGroups-1:0] grp_c;
   logic                 cout;
   flags_t               flags_d;
   flags_t               flags_q;

   // x - y = x + ~y + 1: the +1 enters as the carry into the lowest slice.
   assign y_inv = ~y;

   for (genvar k = 0; k < NumGroups; k++) begin : g_slice
      sub_new_core_cla4 u_cla4 (
         .a_i   (x[4*k +: 4]),
         .b_i   (y_inv[4*k +: 4]),
         .cin_i (grp_c[k]),
         .s_o   (z[4*k +: 4]),
         .p_o   (grp_p[k]),
         .g_o   (grp_g[k])
      );
   end

   // Group carry unit: slice carries from group propagate/generate only.
   always_comb begin
      logic carry;
      grp_c = '0;
      carry = 1'b1;
      for (int k = 0; k < int'(NumGroups); k++) begin
         grp_c[k] = carry;
         carry    = grp_g[k] | (grp_p[k] & carry);
      end
      cout = carry;
   end

   always_comb begin
      flags_d              = '0;
      flags_d[FLAG_BORROW] = ~cout;
      flags_d[FLAG_OVF]    = (x[WIDTH-1] != y[WIDTH-1]) && (z[WIDTH-1] != x[WIDTH-1]);
      flags_d[FLAG_ZERO]   = ~|z;
      flags_d[FLAG_NEG]    = z[WIDTH-1];
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign borrow   = flags_q[FLAG_BORROW];
   assign overflow = flags_q[FLAG_OVF];
   assign zero     = flags_q[FLAG_ZERO];
   assign negative = flags_q[FLAG_NEG];

endmodule

// File: tb/tb_sub_new_core.sv
// Randomized self-checking bench for sub_new_core against an arithmetic model.
module tb_sub_new_core;

   logic        clock;
   logic        clear;
   logic [31:0] x;
   logic [31:0] y;
   logic [31:0] z;
   logic        borrow;
   logic        overflow;
   logic        zero;
   logic        negative;

   int unsigned n_checks;
   int unsigned n_fail;

   sub_new_core #(
      .WIDTH (32)
   ) u_dut (
      .clock    (clock),
      .clear    (clear),
      .x        (x),
      .y        (y),
      .z        (z),
      .borrow   (borrow),
      .overflow (overflow),
      .zero     (zero),
      .negative (negative)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Flags packed as {negative, zero, overflow, borrow}, computed from integer arithmetic.
   function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
      longint sd;
      longint ud;
      logic [31:0] diff;
      logic        ovf;
      ud   = longint'({32'b0, a}) - longint'({32'b0, b});
      sd   = longint'($signed(a)) - longint'($signed(b));
      diff = a - b;
      ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      return {diff[31], diff == 32'd0, ovf, ud < 0};
   endfunction

   function automatic logic [3:0] dut_flags();
      return {negative, zero, overflow, borrow};
   endfunction

   // Drive at the falling edge, check z mid-phase, check flags just after the rising edge.
   task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp_z;
      @(negedge clock);
      x = a;
      y = b;
      exp_z = a - b;
      #1;
      check({tag, ".z"}, z, exp_z);
      @(posedge clock);
      #1;
      check({tag, ".flags"}, {28'b0, dut_flags()}, {28'b0, ref_flags(a, b)});
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corner [5];
      corner = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 4)];
      return $urandom();
   endfunction

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      n_checks = 0;
      n_fail   = 0;
      clear    = 1'b1;
      x        = 32'd0;
      y        = 32'd0;

      @(posedge clock);
      #1;
      check("reset.flags", {28'b0, dut_flags()}, 32'd0);
      @(negedge clock);
      clear = 1'b0;

      // Combinational z without waiting for an edge.
      x = 32'd55;
      y = 32'd555;
      #2;
      check("nodelay.z", z, 32'hFFFF_FE0C);
      @(posedge clock);
      #1;
      check("nodelay.flags", {28'b0, dut_flags()}, {28'b0, 4'b1001});

      apply("zero_minus_one", 32'd0, 32'd1);
      check("zero_minus_one.lit", {28'b0, dut_flags()}, {28'b0, 4'b1001});
      apply("min_minus_one", 32'h8000_0000, 32'd1);
      check("min_minus_one.lit", {28'b0, dut_flags()}, {28'b0, 4'b0010});
      apply("equal", 32'h1234_5678, 32'h1234_5678);
      check("equal.lit", {28'b0, dut_flags()}, {28'b0, 4'b0100});

      // Clear wins over capture; z keeps following the inputs.
      apply("preclear", 32'd0, 32'd1);
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock);
      #1;
      check("clear.flags", {28'b0, dut_flags()}, 32'd0);
      check("clear.z", z, 32'hFFFF_FFFF);
      @(negedge clock);
      clear = 1'b0;
      @(posedge clock);
      #1;
      check("release.flags", {28'b0, dut_flags()}, {28'b0, 4'b1001});

      for (int i = 0; i < 1000; i++) begin
         a = pick_operand();
         b = ($urandom_range(0, 15) == 0) ? a : pick_operand();
         apply("rand", a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
